// File: rtl/main_mem_burst.sv
// Word-granular burst main memory with an explicit burst state machine.
// Big-endian beats, configurable read latency, range/alignment error pulse.
module main_mem_burst #(
    parameter int                        ADDRESS_SIZE  = 32,
    parameter int                        DATA_SIZE     = 32,
    parameter int                        MEM_SIZE      = 1048576,
    parameter logic [ADDRESS_SIZE-1:0]   START_ADDRESS = 32'h80020000,
    parameter int                        MAX_BURST     = 16,
    parameter int                        READ_LATENCY  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [ADDRESS_SIZE-1:0] addr,
    input  logic [1:0]              acc_size,
    input  logic                    wren,
    input  logic [DATA_SIZE-1:0]    d_in,
    output logic [DATA_SIZE-1:0]    d_out,
    output logic                    d_out_valid,
    output logic                    busy,
    output logic                    err
);

    localparam int BYTES = DATA_SIZE / 8;
    localparam int WORDS = MEM_SIZE / BYTES;
    localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int BW    = $clog2(MAX_BURST) + 1;
    localparam int AW    = ADDRESS_SIZE + 1;

    typedef enum logic [2:0] {
        IDLE,
        ERR,
        WR_BURST,
        RD_WAIT,
        RD_BURST
    } state_t;

    // Storage holds whole beats; the MS byte of a word is its lowest byte
    // address, so big-endian order falls out of storing d_in unchanged.
    // Contents rely on the zero power-up value and survive rst.
    logic [DATA_SIZE-1:0] mem [WORDS];

    state_t          state;
    state_t          state_nx;
    logic [IW-1:0]   ptr;
    logic [BW-1:0]   n;
    logic [BW-1:0]   beat;
    logic [3:0]      wcnt;

    logic [4:0]      raw_n;
    logic [4:0]      cap_n;
    logic [BW-1:0]   req_n;
    logic [AW-1:0]   a_ext;
    logic [AW-1:0]   s_ext;
    logic [AW-1:0]   off;
    logic [AW-1:0]   span;
    logic            req_ok;
    logic [IW-1:0]   req_idx;

    logic            mem_we;
    logic [IW-1:0]   widx;
    logic            ld;
    logic [IW-1:0]   ridx;

    // Decode the incoming request: capped beat count, range and alignment.
    always_comb begin
        raw_n = 5'd1;
        unique case (acc_size)
            2'b00: raw_n = 5'd1;
            2'b01: raw_n = 5'd4;
            2'b10: raw_n = 5'd8;
            2'b11: raw_n = 5'd16;
            default: raw_n = 5'd1;
        endcase
        cap_n   = (raw_n > 5'(MAX_BURST)) ? 5'(MAX_BURST) : raw_n;
        req_n   = BW'(cap_n);
        a_ext   = {1'b0, addr};
        s_ext   = {1'b0, START_ADDRESS};
        off     = a_ext - s_ext;
        span    = AW'(req_n) * AW'(BYTES);
        req_ok  = (a_ext >= s_ext)
               && ((off % AW'(BYTES)) == '0)
               && ((off + span) <= AW'(MEM_SIZE));
        req_idx = IW'(off / AW'(BYTES));
    end

    // State register; rst wins over any pending transition.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic plus the per-cycle storage write/read strobes.
    always_comb begin
        state_nx = state;
        mem_we   = 1'b0;
        widx     = ptr;
        ld       = 1'b0;
        ridx     = ptr;
        unique case (state)
            IDLE: begin
                if (en) begin
                    if (!req_ok) begin
                        state_nx = ERR;
                    end else if (wren) begin
                        mem_we   = 1'b1;
                        widx     = req_idx;
                        state_nx = (req_n == BW'(1)) ? IDLE : WR_BURST;
                    end else if (READ_LATENCY > 1) begin
                        state_nx = RD_WAIT;
                    end else begin
                        state_nx = RD_BURST;
                        ld       = 1'b1;
                        ridx     = req_idx;
                    end
                end
            end
            ERR: state_nx = IDLE;
            WR_BURST: begin
                mem_we = 1'b1;
                if (beat == n - BW'(1)) state_nx = IDLE;
            end
            RD_WAIT: begin
                if (wcnt == 4'(READ_LATENCY - 2)) begin
                    state_nx = RD_BURST;
                    ld       = 1'b1;
                end
            end
            RD_BURST: begin
                if (beat == n) state_nx = IDLE;
                else           ld       = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Burst bookkeeping and the registered read beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr         <= '0;
            n           <= '0;
            beat        <= '0;
            wcnt        <= '0;
            d_out       <= '0;
            d_out_valid <= 1'b0;
        end else begin
            d_out_valid <= ld;
            d_out       <= ld ? mem[ridx] : '0;
            if (state == IDLE) begin
                n    <= req_n;
                beat <= '0;
                wcnt <= '0;
                ptr  <= req_idx;
            end
            if (state == RD_WAIT) wcnt <= wcnt + 4'd1;
            if (mem_we || ld) begin
                ptr  <= (ld ? ridx : widx) + IW'(1);
                beat <= (state == IDLE) ? BW'(1) : beat + BW'(1);
            end
        end
    end

    // Commit each write beat at its own edge; a reset edge writes nothing.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) mem[widx] <= d_in;
    end

    assign busy = (state != IDLE);
    assign err  = (state == ERR);

endmodule
